// File: rtl/nco_sweep_ctrl.sv
// Stepped linear phase-increment sweep generator feeding the NCO (phi_inc_o / clken_o).
// Define NCO_SWEEP_TRI_EN to build a triangle (up/down) sweep instead of the default sawtooth.
module nco_sweep_ctrl #(
    parameter int apr = 32,
    parameter int nsw = 16,
    parameter int dww = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [apr-1:0] cfg_start_inc,
    input  logic [apr-1:0] cfg_step_inc,
    input  logic [nsw-1:0] cfg_num_steps,
    input  logic [dww-1:0] cfg_dwell,
    input  logic           cfg_cont,
    input  logic           start,
    input  logic           abort,
    output logic [apr-1:0] phi_inc_o,
    output logic           clken_o,
    output logic           busy,
    output logic           step_strobe,
    output logic           done,
    output logic [nsw-1:0] step_idx
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_q;
    logic [apr-1:0] step_q;
    logic [nsw-1:0] nsteps_q;
    logic [dww-1:0] dwell_q;
    logic           cont_q;
    logic [dww-1:0] dwell_cnt_q;
    logic [apr-1:0] phi_q;
    logic [nsw-1:0] idx_q;
    logic           clken_q, busy_q, strobe_q, done_q;
`ifdef NCO_SWEEP_TRI_EN
    logic           dir_q;   // 0 = ascending, 1 = descending
`else
    logic [apr-1:0] start_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            step_q      <= '0;
            nsteps_q    <= '0;
            dwell_q     <= '0;
            cont_q      <= 1'b0;
            dwell_cnt_q <= '0;
            phi_q       <= '0;
            idx_q       <= '0;
            clken_q     <= 1'b0;
            busy_q      <= 1'b0;
            strobe_q    <= 1'b0;
            done_q      <= 1'b0;
`ifdef NCO_SWEEP_TRI_EN
            dir_q       <= 1'b0;
`else
            start_q     <= '0;
`endif
        end else begin
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            if (abort) begin
                // Abort outranks start and terminal count; increment and index are frozen.
                state_q <= IDLE;
                busy_q  <= 1'b0;
                clken_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            step_q      <= cfg_step_inc;
                            nsteps_q    <= cfg_num_steps;
                            dwell_q     <= cfg_dwell;
                            cont_q      <= cfg_cont;
                            state_q     <= RUN;
                            busy_q      <= 1'b1;
                            clken_q     <= 1'b1;
                            phi_q       <= cfg_start_inc;
                            idx_q       <= '0;
                            dwell_cnt_q <= '0;
`ifdef NCO_SWEEP_TRI_EN
                            dir_q       <= 1'b0;
`else
                            start_q     <= cfg_start_inc;
`endif
                        end
                    end
                    RUN: begin
                        if (dwell_cnt_q != dwell_q) begin
                            dwell_cnt_q <= dwell_cnt_q + dww'(1);
                        end else begin
                            dwell_cnt_q <= '0;
`ifdef NCO_SWEEP_TRI_EN
                            if (!dir_q && idx_q != nsteps_q) begin
                                phi_q    <= phi_q + step_q;
                                idx_q    <= idx_q + nsw'(1);
                                strobe_q <= 1'b1;
                            end else if (!dir_q && nsteps_q != '0) begin
                                // Peak reached: turn around immediately so the top value is held only one dwell.
                                dir_q    <= 1'b1;
                                phi_q    <= phi_q - step_q;
                                idx_q    <= idx_q - nsw'(1);
                                strobe_q <= 1'b1;
                            end else if (dir_q && idx_q != '0) begin
                                phi_q    <= phi_q - step_q;
                                idx_q    <= idx_q - nsw'(1);
                                strobe_q <= 1'b1;
                            end else begin
                                done_q <= 1'b1;
                                if (cont_q) begin
                                    dir_q <= 1'b0;
                                    if (nsteps_q != '0) begin
                                        phi_q    <= phi_q + step_q;
                                        idx_q    <= idx_q + nsw'(1);
                                        strobe_q <= 1'b1;
                                    end
                                end else begin
                                    state_q <= IDLE;
                                    busy_q  <= 1'b0;
                                    clken_q <= 1'b0;
                                end
                            end
`else
                            if (idx_q != nsteps_q) begin
                                phi_q    <= phi_q + step_q;
                                idx_q    <= idx_q + nsw'(1);
                                strobe_q <= 1'b1;
                            end else begin
                                done_q <= 1'b1;
                                if (cont_q) begin
                                    phi_q    <= start_q;
                                    idx_q    <= '0;
                                    strobe_q <= 1'b1;
                                end else begin
                                    state_q <= IDLE;
                                    busy_q  <= 1'b0;
                                    clken_q <= 1'b0;
                                end
                            end
`endif
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign phi_inc_o   = phi_q;
    assign clken_o     = clken_q;
    assign busy        = busy_q;
    assign step_strobe = strobe_q;
    assign done        = done_q;
    assign step_idx    = idx_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed self-checking bench for nco_sweep_ctrl; outputs sampled on the falling edge.
module tb_nco_sweep_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] cfg_start_inc = '0;
    logic [31:0] cfg_step_inc = '0;
    logic [15:0] cfg_num_steps = '0;
    logic [15:0] cfg_dwell = '0;
    logic        cfg_cont = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] phi_inc_o;
    logic        clken_o, busy, step_strobe, done;
    logic [15:0] step_idx;

    int npass = 0;
    int ntotal = 0;

    nco_sweep_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_start_inc(cfg_start_inc), .cfg_step_inc(cfg_step_inc),
        .cfg_num_steps(cfg_num_steps), .cfg_dwell(cfg_dwell), .cfg_cont(cfg_cont),
        .start(start), .abort(abort),
        .phi_inc_o(phi_inc_o), .clken_o(clken_o), .busy(busy),
        .step_strobe(step_strobe), .done(done), .step_idx(step_idx)
    );

    always #5 clk = ~clk;

    // Returns at the falling edge right after the start edge (cycle 0 of the sweep).
    task automatic launch(input logic [31:0] s, input logic [31:0] st,
                          input logic [15:0] n, input logic [15:0] d, input logic c);
        @(negedge clk);
        cfg_start_inc = s; cfg_step_inc = st; cfg_num_steps = n; cfg_dwell = d; cfg_cont = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [52:0] outs;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            outs = {phi_inc_o, clken_o, busy, step_strobe, done, step_idx};
            ntotal++;
            if (outs !== 53'd0) $display("FAIL reset_idle c=%0d: got %h exp 0", c, outs);
            else npass++;
        end
    endtask

    task automatic test_reset_mid();
        launch(32'h00000400, 32'h00000040, 16'd4, 16'd1, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        ntotal++;
        if ({phi_inc_o, clken_o, busy, step_strobe, done, step_idx} !== 53'd0)
            $display("FAIL reset_mid: got phi=%h clken=%b busy=%b idx=%0d exp all 0",
                     phi_inc_o, clken_o, busy, step_idx);
        else npass++;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_abort();
        launch(32'h00000100, 32'h00000010, 16'd5, 16'd1, 1'b0);
        for (int c = 0; c < 4; c++) @(negedge clk);
        ntotal++;
        if (step_idx !== 16'd2 || phi_inc_o !== 32'h00000120)
            $display("FAIL abort_pre: got idx=%0d phi=%h exp 2 00000120", step_idx, phi_inc_o);
        else npass++;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        ntotal++;
        if (busy !== 1'b0 || clken_o !== 1'b0 || done !== 1'b0 || step_strobe !== 1'b0 ||
            phi_inc_o !== 32'h00000120)
            $display("FAIL abort_stop: got busy=%b clken=%b done=%b strobe=%b phi=%h exp 0 0 0 0 00000120",
                     busy, clken_o, done, step_strobe, phi_inc_o);
        else npass++;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            ntotal++;
            if (busy !== 1'b0 || done !== 1'b0 || clken_o !== 1'b0)
                $display("FAIL abort_idle c=%0d: got busy=%b done=%b clken=%b exp 0 0 0", c, busy, done, clken_o);
            else npass++;
        end
    endtask

    task automatic test_abort_start();
        @(negedge clk);
        cfg_start_inc = 32'h00000777; cfg_num_steps = 16'd2; cfg_dwell = 16'd0; cfg_cont = 1'b0;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        for (int c = 0; c < 4; c++) begin
            ntotal++;
            if (busy !== 1'b0 || clken_o !== 1'b0 || phi_inc_o === 32'h00000777)
                $display("FAIL abort_start c=%0d: got busy=%b clken=%b phi=%h exp idle", c, busy, clken_o, phi_inc_o);
            else npass++;
            @(negedge clk);
        end
    endtask

`ifdef NCO_SWEEP_TRI_EN
    task automatic test_triangle();
        logic [31:0] exp_phi [5] = '{32'd100, 32'd110, 32'd120, 32'd110, 32'd100};
        logic [15:0] exp_idx [5] = '{16'd0, 16'd1, 16'd2, 16'd1, 16'd0};
        launch(32'd100, 32'd10, 16'd2, 16'd0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            ntotal++;
            if (phi_inc_o !== exp_phi[c] || step_idx !== exp_idx[c] || clken_o !== 1'b1 || done !== 1'b0)
                $display("FAIL tri c=%0d: got phi=%0d idx=%0d clken=%b done=%b exp %0d %0d 1 0",
                         c, phi_inc_o, step_idx, clken_o, done, exp_phi[c], exp_idx[c]);
            else npass++;
            @(negedge clk);
        end
        ntotal++;
        if (done !== 1'b1 || busy !== 1'b0 || clken_o !== 1'b0 || phi_inc_o !== 32'd100)
            $display("FAIL tri_done: got done=%b busy=%b clken=%b phi=%0d exp 1 0 0 100",
                     done, busy, clken_o, phi_inc_o);
        else npass++;
        @(negedge clk);
    endtask
`else
    task automatic test_single_sweep();
        logic [31:0] exp_phi [8] = '{32'h01000000, 32'h01000000, 32'h01100000, 32'h01100000,
                                     32'h01200000, 32'h01200000, 32'h01300000, 32'h01300000};
        int n_clken = 0, n_strobe = 0, n_done = 0;
        launch(32'h01000000, 32'h00100000, 16'd3, 16'd1, 1'b0);
        for (int c = 0; c < 8; c++) begin
            ntotal++;
            if (phi_inc_o !== exp_phi[c] || busy !== 1'b1 || done !== 1'b0)
                $display("FAIL single c=%0d: got phi=%h busy=%b done=%b exp %h 1 0",
                         c, phi_inc_o, busy, done, exp_phi[c]);
            else npass++;
            n_clken += int'(clken_o); n_strobe += int'(step_strobe); n_done += int'(done);
            // A start pulse and new config mid-sweep must be ignored.
            start = (c == 3);
            cfg_step_inc = (c == 3) ? 32'h7FFF0000 : cfg_step_inc;
            @(negedge clk);
        end
        ntotal++;
        if (done !== 1'b1 || busy !== 1'b0 || clken_o !== 1'b0 || phi_inc_o !== 32'h01300000 || step_idx !== 16'd3)
            $display("FAIL single_done: got done=%b busy=%b clken=%b phi=%h idx=%0d exp 1 0 0 01300000 3",
                     done, busy, clken_o, phi_inc_o, step_idx);
        else npass++;
        for (int c = 0; c < 6; c++) begin
            n_clken += int'(clken_o); n_strobe += int'(step_strobe); n_done += int'(done);
            @(negedge clk);
        end
        ntotal++;
        if (n_clken !== 8 || n_strobe !== 3 || n_done !== 1)
            $display("FAIL single_counts: got clken=%0d strobe=%0d done=%0d exp 8 3 1", n_clken, n_strobe, n_done);
        else npass++;
    endtask

    task automatic test_neg_wrap();
        logic [31:0] exp_phi [3] = '{32'h00000010, 32'h00000000, 32'hFFFFFFF0};
        logic        exp_stb [3] = '{1'b0, 1'b1, 1'b1};
        launch(32'h00000010, 32'hFFFFFFF0, 16'd2, 16'd0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            ntotal++;
            if (phi_inc_o !== exp_phi[c] || step_strobe !== exp_stb[c] || step_idx !== 16'(c))
                $display("FAIL wrap c=%0d: got phi=%h strobe=%b idx=%0d exp %h %b %0d",
                         c, phi_inc_o, step_strobe, step_idx, exp_phi[c], exp_stb[c], c);
            else npass++;
            @(negedge clk);
        end
        ntotal++;
        if (done !== 1'b1 || clken_o !== 1'b0 || phi_inc_o !== 32'hFFFFFFF0)
            $display("FAIL wrap_done: got done=%b clken=%b phi=%h exp 1 0 fffffff0", done, clken_o, phi_inc_o);
        else npass++;
        @(negedge clk);
    endtask

    task automatic test_n_zero();
        launch(32'h0000ABCD, 32'h00000001, 16'd0, 16'd3, 1'b0);
        for (int c = 0; c < 4; c++) begin
            ntotal++;
            if (phi_inc_o !== 32'h0000ABCD || clken_o !== 1'b1 || step_strobe !== 1'b0 || done !== 1'b0)
                $display("FAIL nzero c=%0d: got phi=%h clken=%b strobe=%b done=%b exp 0000abcd 1 0 0",
                         c, phi_inc_o, clken_o, step_strobe, done);
            else npass++;
            @(negedge clk);
        end
        ntotal++;
        if (done !== 1'b1 || clken_o !== 1'b0)
            $display("FAIL nzero_done: got done=%b clken=%b exp 1 0", done, clken_o);
        else npass++;
        @(negedge clk);
    endtask

    task automatic test_cont();
        logic        exp_done;
        logic [31:0] exp_phi;
        launch(32'h00001000, 32'h00000100, 16'd1, 16'd2, 1'b1);
        for (int c = 0; c < 24; c++) begin
            exp_done = (c % 6 == 0) && (c != 0);
            exp_phi  = ((c % 6) < 3) ? 32'h00001000 : 32'h00001100;
            ntotal++;
            if (done !== exp_done || phi_inc_o !== exp_phi || busy !== 1'b1 || clken_o !== 1'b1)
                $display("FAIL cont c=%0d: got done=%b phi=%h busy=%b clken=%b exp %b %h 1 1",
                         c, done, phi_inc_o, busy, clken_o, exp_done, exp_phi);
            else npass++;
            if (c == 1) cfg_start_inc = 32'hDEAD0000;
            // Abort lands on a terminal count: it must win and suppress done.
            abort = (c == 23);
            @(negedge clk);
        end
        abort = 1'b0;
        ntotal++;
        if (done !== 1'b0 || step_strobe !== 1'b0 || busy !== 1'b0 || clken_o !== 1'b0 || phi_inc_o !== 32'h00001100)
            $display("FAIL cont_abort: got done=%b strobe=%b busy=%b clken=%b phi=%h exp 0 0 0 0 00001100",
                     done, step_strobe, busy, clken_o, phi_inc_o);
        else npass++;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
`ifdef NCO_SWEEP_TRI_EN
        test_triangle();
`else
        test_single_sweep();
        test_neg_wrap();
        test_n_zero();
        test_cont();
`endif
        test_abort();
        test_abort_start();
        test_reset_mid();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
